// File: rtl/ga_pkg.sv
// Shared types and seed-sequence helpers for the GA batch sequencer.
package ga_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RST     = 3'd1,
    S_RUN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_NEXT    = 3'd4,
    S_DONE    = 3'd5
  } ga_batch_state_t;

  localparam logic [31:0] GA_SEED_TAPS = 32'h80200003;

  // An all-zero seed would lock the core's LFSR, so it is replaced by 1.
  function automatic logic [31:0] ga_seed_fix(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  // One step of the right-shift Galois LFSR, with zero substitution.
  function automatic logic [31:0] ga_seed_next(input logic [31:0] s);
    logic [31:0] n;
    n = (s >> 1) ^ (s[0] ? GA_SEED_TAPS : 32'd0);
    return ga_seed_fix(n);
  endfunction

endpackage

// File: rtl/ga_seed_lfsr.sv
// Seed register for the GA core: loads the batch seed or steps the LFSR.
module ga_seed_lfsr
  import ga_pkg::*;
#(
  parameter logic [31:0] SEED_INIT = 32'h895C80A7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        adv_i,
  output logic [31:0] seed_o
);

  logic [31:0] seed_q, seed_d;

  // Load has priority; the register holds otherwise so the seed stays stable through a run.
  always_comb begin
    seed_d = seed_q;
    if (load_i)     seed_d = ga_seed_fix(SEED_INIT);
    else if (adv_i) seed_d = ga_seed_next(seed_q);
  end

  // Seed state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) seed_q <= SEED_INIT;
    else     seed_q <= seed_d;
  end

  assign seed_o = seed_q;

endmodule

// File: rtl/ga_batch_ctrl.sv
// Batch sequencer: runs the GA core RUNS times with fresh seeds, watchdogs
// each run, and tracks the best chromosome seen across the batch.
module ga_batch_ctrl
  import ga_pkg::*;
#(
  parameter int          RUNS          = 8,
  parameter int          CHROM_WIDTH   = 16,
  parameter int          FITNESS_WIDTH = 51,
  parameter logic [31:0] SEED_INIT     = 32'h895C80A7,
  parameter int          RST_CYCLES    = 2,
  parameter int          WATCHDOG      = 65536,
  localparam int         RW            = $clog2(RUNS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  output logic                     ga_reset,
  output logic [31:0]              ga_seed,
  input  logic                     ga_finished,
  input  logic [CHROM_WIDTH-1:0]   ga_best,
  input  logic [FITNESS_WIDTH-1:0] ga_best_fit,
  output logic                     busy,
  output logic                     done,
  output logic [CHROM_WIDTH-1:0]   best,
  output logic [FITNESS_WIDTH-1:0] best_fit,
  output logic [RW-1:0]            best_run,
  output logic                     best_valid,
  output logic [RW-1:0]            runs_done,
  output logic [RW-1:0]            aborted_runs
);

  localparam int WW = $clog2(WATCHDOG + 1);
  localparam int CW = $clog2(RST_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WATCHDOG - 1);
  localparam logic [CW-1:0] RC_LAST = CW'(RST_CYCLES - 1);
  localparam logic [RW-1:0] RUNS_L  = RW'(RUNS);

  ga_batch_state_t          state_q, state_d;
  logic [CW-1:0]            rst_cnt_q, rst_cnt_d;
  logic [WW-1:0]            wd_cnt_q, wd_cnt_d;
  logic [RW-1:0]            run_idx_q, run_idx_d;
  logic [CHROM_WIDTH-1:0]   best_q, best_d;
  logic [FITNESS_WIDTH-1:0] best_fit_q, best_fit_d;
  logic [RW-1:0]            best_run_q, best_run_d;
  logic                     best_valid_q, best_valid_d;
  logic [RW-1:0]            runs_done_q, runs_done_d;
  logic [RW-1:0]            aborted_q, aborted_d;
  logic                     seed_load, seed_adv;

  assign busy     = (state_q == S_RST) || (state_q == S_RUN) ||
                    (state_q == S_CAPTURE) || (state_q == S_NEXT);
  assign done     = (state_q == S_DONE);
  assign ga_reset = (state_q != S_RUN);

  ga_seed_lfsr #(.SEED_INIT(SEED_INIT)) u_seed (
    .clk    (clk),
    .rst    (reset),
    .load_i (seed_load),
    .adv_i  (seed_adv),
    .seed_o (ga_seed)
  );

  // Next-state logic: stop overrides everything while busy, so a finish in the same cycle is dropped.
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    run_idx_d    = run_idx_q;
    best_d       = best_q;
    best_fit_d   = best_fit_q;
    best_run_d   = best_run_q;
    best_valid_d = best_valid_q;
    runs_done_d  = runs_done_q;
    aborted_d    = aborted_q;
    seed_load    = 1'b0;
    seed_adv     = 1'b0;
    if (busy && stop) begin
      state_d = S_DONE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start) begin
          state_d      = S_RST;
          seed_load    = 1'b1;
          run_idx_d    = '0;
          rst_cnt_d    = '0;
          best_d       = '0;
          best_fit_d   = '0;
          best_run_d   = '0;
          best_valid_d = 1'b0;
          runs_done_d  = '0;
          aborted_d    = '0;
        end
        S_RST: begin
          if (rst_cnt_q == RC_LAST) begin
            state_d  = S_RUN;
            wd_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (ga_finished) begin
            state_d = S_CAPTURE;
          end else if (wd_cnt_q == WD_LAST) begin
            aborted_d = aborted_q + 1'b1;
            state_d   = S_NEXT;
          end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
        end
        S_CAPTURE: begin
          // Strict compare: ties keep the earlier run.
          if (!best_valid_q || (ga_best_fit > best_fit_q)) begin
            best_d       = ga_best;
            best_fit_d   = ga_best_fit;
            best_run_d   = run_idx_q;
            best_valid_d = 1'b1;
          end
          state_d = S_NEXT;
        end
        S_NEXT: begin
          runs_done_d = runs_done_q + 1'b1;
          if (runs_done_d == RUNS_L) begin
            state_d = S_DONE;
          end else begin
            seed_adv  = 1'b1;
            run_idx_d = run_idx_q + 1'b1;
            rst_cnt_d = '0;
            state_d   = S_RST;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= '0;
      wd_cnt_q     <= '0;
      run_idx_q    <= '0;
      best_q       <= '0;
      best_fit_q   <= '0;
      best_run_q   <= '0;
      best_valid_q <= 1'b0;
      runs_done_q  <= '0;
      aborted_q    <= '0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      run_idx_q    <= run_idx_d;
      best_q       <= best_d;
      best_fit_q   <= best_fit_d;
      best_run_q   <= best_run_d;
      best_valid_q <= best_valid_d;
      runs_done_q  <= runs_done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign best         = best_q;
  assign best_fit     = best_fit_q;
  assign best_run     = best_run_q;
  assign best_valid   = best_valid_q;
  assign runs_done    = runs_done_q;
  assign aborted_runs = aborted_q;

endmodule

// File: tb/tb_ga_batch_ctrl.sv
// Bench for ga_batch_ctrl: a stub GA driven from per-run tables, results
// compared against a batch-level model of best/abort bookkeeping.
module tb_ga_batch_ctrl;
  import ga_pkg::*;

  localparam int RUNS = 4, CWD = 16, FW = 51, WD = 100, RC = 2, RW = $clog2(RUNS + 1);
  localparam logic [31:0] SEED = 32'h895C80A7;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0;
  logic ga_finished = 1'b0;
  logic [CWD-1:0] ga_best = '0;
  logic [FW-1:0] ga_best_fit = '0;
  logic ga_reset, busy, done, best_valid;
  logic [31:0] ga_seed;
  logic [CWD-1:0] best;
  logic [FW-1:0] best_fit;
  logic [RW-1:0] best_run, runs_done, aborted_runs;
  // second instance with a zero seed, sharing the same stimulus
  logic ga_reset0, busy0, done0, best_valid0;
  logic [31:0] ga_seed0;
  logic [CWD-1:0] best0;
  logic [FW-1:0] best_fit0;
  logic [RW-1:0] best_run0, runs_done0, aborted_runs0;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ga_batch_ctrl #(.RUNS(RUNS), .CHROM_WIDTH(CWD), .FITNESS_WIDTH(FW), .SEED_INIT(SEED),
                  .RST_CYCLES(RC), .WATCHDOG(WD)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .ga_reset(ga_reset), .ga_seed(ga_seed),
    .ga_finished(ga_finished), .ga_best(ga_best), .ga_best_fit(ga_best_fit), .busy(busy), .done(done),
    .best(best), .best_fit(best_fit), .best_run(best_run), .best_valid(best_valid),
    .runs_done(runs_done), .aborted_runs(aborted_runs));

  ga_batch_ctrl #(.RUNS(RUNS), .CHROM_WIDTH(CWD), .FITNESS_WIDTH(FW), .SEED_INIT(32'h0),
                  .RST_CYCLES(RC), .WATCHDOG(WD)) dut0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .ga_reset(ga_reset0), .ga_seed(ga_seed0),
    .ga_finished(ga_finished), .ga_best(ga_best), .ga_best_fit(ga_best_fit), .busy(busy0), .done(done0),
    .best(best0), .best_fit(best_fit0), .best_run(best_run0), .best_valid(best_valid0),
    .runs_done(runs_done0), .aborted_runs(aborted_runs0));

  typedef struct {
    logic [RUNS-1:0][FW-1:0] fits;
    logic [RUNS-1:0]         ab;
    int                      lat;
    logic [FW-1:0]           exp_fit;
    int                      exp_run;
    logic                    exp_valid;
    int                      exp_ab;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [CWD-1:0] chrom_of(input logic [FW-1:0] f, input int r);
    return f[CWD-1:0] ^ 16'h5A5A ^ CWD'(r);
  endfunction

  // Batch-level reference: best over completed runs, earliest run wins ties.
  function automatic vec_t model(input vec_t v);
    vec_t o;
    o = v; o.exp_fit = '0; o.exp_run = 0; o.exp_valid = 1'b0; o.exp_ab = 0;
    for (int r = 0; r < RUNS; r++) begin
      if (v.ab[r]) o.exp_ab++;
      else if (!o.exp_valid || v.fits[r] > o.exp_fit) begin
        o.exp_fit = v.fits[r]; o.exp_run = r; o.exp_valid = 1'b1;
      end
    end
    return o;
  endfunction

  // Count cycles until the core is released (ga_reset low); bounded.
  task automatic wait_run(output int n);
    n = 0;
    while (ga_reset && n < 1000) begin n++; @(negedge clk); end
    if (n >= 1000) begin errors++; $display("FAIL wait_run timeout"); end
  endtask

  task automatic run_batch(input vec_t v, input bit pk);
    int n, m;
    logic [31:0] s;
    s = ga_seed_fix(SEED);
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int r = 0; r < RUNS; r++) begin
      wait_run(n);
      if (r == 0) chk("rst_len_r0", 64'(n), 64'(RC));
      else        chk("rst_len", 64'(n), 64'(RC + (v.ab[r-1] ? 1 : 2)));
      chk("seed", 64'(ga_seed), 64'(s));
      if (r == 0) chk("seed0_zero_sub", 64'(ga_seed0), 64'h1);
      s = ga_seed_next(s);
      if (v.ab[r]) begin
        m = 0;
        while (!ga_reset && m < 1000) begin m++; @(negedge clk); end
        chk("watchdog_len", 64'(m), 64'(WD));
      end else begin
        if (pk && r == 1) begin
          start = 1'b1; @(negedge clk); start = 1'b0;
          chk("start_ign_busy", 64'(busy), 64'h1);
          chk("start_ign_gareset", 64'(ga_reset), 64'h0);
          chk("start_ign_runs", 64'(runs_done), 64'h1);
        end
        repeat (v.lat) @(negedge clk);
        chk("still_running", 64'(ga_reset), 64'h0);
        ga_finished = 1'b1; ga_best_fit = v.fits[r]; ga_best = chrom_of(v.fits[r], r);
        @(negedge clk);
        ga_finished = 1'b0;
      end
    end
    m = 0;
    while (!done && m < 20) begin m++; @(negedge clk); end
    chk("done", 64'(done), 64'h1);
    chk("busy_end", 64'(busy), 64'h0);
    chk("ga_reset_done", 64'(ga_reset), 64'h1);
    chk("best_fit", 64'(best_fit), 64'(v.exp_fit));
    chk("best_run", 64'(best_run), 64'(v.exp_run));
    chk("best_valid", 64'(best_valid), 64'(v.exp_valid));
    chk("best", 64'(best), v.exp_valid ? 64'(chrom_of(v.fits[v.exp_run], v.exp_run)) : 64'h0);
    chk("runs_done", 64'(runs_done), 64'(RUNS));
    chk("aborted", 64'(aborted_runs), 64'(v.exp_ab));
  endtask

  vec_t tbl [5];

  initial begin
    int n;
    vec_t rv;
    // {fits run0..run3 (index 3 first), abort mask, latency, expected fit/run/valid/aborted}
    tbl[0] = '{fits: {51'd5, 51'd30, 51'd30, 51'd10}, ab: 4'b0000, lat: 3,
               exp_fit: 51'd30, exp_run: 1, exp_valid: 1'b1, exp_ab: 0};
    tbl[1] = '{fits: {51'd70, 51'd99, 51'd20, 51'd50}, ab: 4'b0100, lat: 5,
               exp_fit: 51'd70, exp_run: 3, exp_valid: 1'b1, exp_ab: 1};
    tbl[2] = '{fits: {51'd1, 51'd2, 51'd3, 51'd4}, ab: 4'b1111, lat: 0,
               exp_fit: 51'd0, exp_run: 0, exp_valid: 1'b0, exp_ab: 4};
    tbl[3] = '{fits: {51'd0, 51'h7FFFFFFFFFFFF, 51'd3, 51'h7FFFFFFFFFFFF}, ab: 4'b0000, lat: 0,
               exp_fit: 51'h7FFFFFFFFFFFF, exp_run: 0, exp_valid: 1'b1, exp_ab: 0};
    tbl[4] = '{fits: {51'd0, 51'd0, 51'd0, 51'd9}, ab: 4'b0001, lat: 1,
               exp_fit: 51'd0, exp_run: 1, exp_valid: 1'b1, exp_ab: 1};

    #12;
    chk("rst_ga_reset", 64'(ga_reset), 64'h1);
    chk("rst_seed", 64'(ga_seed), 64'(SEED));
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_best", 64'(best), 64'h0);
    chk("rst_best_fit", 64'(best_fit), 64'h0);
    chk("rst_best_run", 64'(best_run), 64'h0);
    chk("rst_best_valid", 64'(best_valid), 64'h0);
    chk("rst_runs_done", 64'(runs_done), 64'h0);
    chk("rst_aborted", 64'(aborted_runs), 64'h0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    chk("stop_idle_ignored", 64'(done), 64'h0);

    for (int i = 0; i < 5; i++) run_batch(tbl[i], (i == 0));

    // stop in RUN of run 1 with a simultaneous finish: stop wins
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_run(n);
    repeat (2) @(negedge clk);
    ga_finished = 1'b1; ga_best_fit = 51'd7; ga_best = 16'h1234;
    @(negedge clk); ga_finished = 1'b0;
    wait_run(n);
    ga_finished = 1'b1; ga_best_fit = 51'd99; ga_best = 16'hBEEF; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; ga_finished = 1'b0;
    chk("stop_done", 64'(done), 64'h1);
    chk("stop_ga_reset", 64'(ga_reset), 64'h1);
    chk("stop_busy", 64'(busy), 64'h0);
    chk("stop_runs_done", 64'(runs_done), 64'h1);
    chk("stop_best_fit", 64'(best_fit), 64'd7);
    chk("stop_best_run", 64'(best_run), 64'h0);
    chk("stop_best", 64'(best), 64'h1234);
    repeat (3) @(negedge clk);
    chk("stop_done_held", 64'(done), 64'h1);

    // async reset in RUN of run 2, between clock edges
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      wait_run(n);
      ga_finished = 1'b1; ga_best_fit = 51'(20 + r); ga_best = 16'h00A0;
      @(negedge clk); ga_finished = 1'b0;
    end
    wait_run(n);
    #2 reset = 1'b1;
    #1;
    chk("arst_ga_reset", 64'(ga_reset), 64'h1);
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_seed", 64'(ga_seed), 64'(SEED));
    chk("arst_best_fit", 64'(best_fit), 64'h0);
    chk("arst_best_valid", 64'(best_valid), 64'h0);
    chk("arst_runs_done", 64'(runs_done), 64'h0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    run_batch(tbl[1], 1'b0);

    // randomized batches against the model
    for (int b = 0; b < 6; b++) begin
      rv = tbl[0];
      for (int r = 0; r < RUNS; r++) begin
        rv.fits[r] = ($urandom_range(0, 3) == 0) ? {19'($urandom), $urandom} : 51'($urandom_range(0, 7));
        rv.ab[r]   = ($urandom_range(0, 4) == 0);
      end
      rv.lat = $urandom_range(0, 20);
      run_batch(model(rv), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
